// File: rtl/mem_port_seq.sv
// Request sequencer in front of a 1K x 16 single-port block RAM with registered outputs.
// Optional whole-memory zero-fill sweep is compiled in when MEMSEQ_CLEAR_EN is defined.
module mem_port_seq #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clka,
    input  logic              rsta_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              clear_start,
    output logic              clear_done,
    output logic              mem_wea,
    output logic [ADDR_W-1:0] mem_addra,
    output logic [DATA_W-1:0] mem_dina,
    input  logic [DATA_W-1:0] mem_douta
);

    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              clear_done_q, clear_done_d;
    logic              mem_wea_q, mem_wea_d;
    logic [ADDR_W-1:0] mem_addra_q, mem_addra_d;
    logic [DATA_W-1:0] mem_dina_q, mem_dina_d;
    // Bit 0: read issued last edge; bit 1: memory has produced its data.
    logic [1:0]        rd_tag_q, rd_tag_d;
    logic              accept;

`ifdef MEMSEQ_CLEAR_EN
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
`else
    logic              unused_clear_start;
    assign unused_clear_start = clear_start;
`endif

    assign accept = req_valid && req_ready_q;

    always_comb begin
        mem_wea_d    = 1'b0;
        mem_addra_d  = mem_addra_q;
        mem_dina_d   = mem_dina_q;
        clear_done_d = 1'b0;
        rd_tag_d     = {rd_tag_q[0], 1'b0};
        rsp_valid_d  = rd_tag_q[1];
        rsp_rdata_d  = rd_tag_q[1] ? mem_douta : rsp_rdata_q;

        if (accept) begin
            mem_wea_d   = req_we;
            mem_addra_d = req_addr;
            rd_tag_d[0] = ~req_we;
            if (req_we) begin
                mem_dina_d = req_wdata;
            end
        end

`ifdef MEMSEQ_CLEAR_EN
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            IDLE: begin
                // A request accepted on this same edge has already been issued above.
                if (clear_start) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            CLEAR: begin
                mem_wea_d   = 1'b1;
                mem_addra_d = clr_cnt_q;
                mem_dina_d  = '0;
                if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                    clear_done_d = 1'b1;
                    state_d      = IDLE;
                    clr_cnt_d    = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                clr_cnt_d = '0;
            end
        endcase
        req_ready_d = (state_d == IDLE);
`else
        req_ready_d = 1'b1;
`endif
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            clear_done_q <= 1'b0;
            mem_wea_q    <= 1'b0;
            mem_addra_q  <= '0;
            mem_dina_q   <= '0;
            rd_tag_q     <= '0;
`ifdef MEMSEQ_CLEAR_EN
            state_q      <= IDLE;
            clr_cnt_q    <= '0;
`endif
        end else begin
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            clear_done_q <= clear_done_d;
            mem_wea_q    <= mem_wea_d;
            mem_addra_q  <= mem_addra_d;
            mem_dina_q   <= mem_dina_d;
            rd_tag_q     <= rd_tag_d;
`ifdef MEMSEQ_CLEAR_EN
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
`endif
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign clear_done = clear_done_q;
    assign mem_wea    = mem_wea_q;
    assign mem_addra  = mem_addra_q;
    assign mem_dina   = mem_dina_q;

endmodule
